// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage with a small prefetch FIFO feeding ID.
// Keeps fetching through ID stalls; redirects flush queue and in-flight fetch.
module if_prefetch_queue #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned OW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            control_j,
    input  logic [XLEN-1:0] pc_j,
    input  logic [XLEN-1:0] ins_data,
    input  logic            pipe_ready,
    output logic            ins_req,
    output logic [XLEN-1:0] ins_addr,
    output logic            pipe_valid,
    output logic [XLEN-1:0] pipe_pc,
    output logic [XLEN-1:0] pipe_pc4,
    output logic [XLEN-1:0] pipe_data,
    output logic [OW-1:0]   occupancy
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    localparam logic [OW:0] DEPTH_W = (OW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [OW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] pc4_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [OW:0]     credit;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit counts the in-flight fetch so a returning response always has room.
    always_comb begin
        credit = {1'b0, count_q} + {{OW{1'b0}}, inflight_q};
        ins_req = !reset && !control_j && (credit < DEPTH_W);
        ins_addr = fetch_pc_q;
        push = inflight_q && !control_j;
        pop = pipe_valid && pipe_ready && !control_j;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;
        if (control_j) begin
            fetch_pc_d = pc_j;
            inflight_d = 1'b0;
            head_d = '0;
            tail_d = '0;
            count_d = '0;
        end else begin
            if (ins_req) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            inflight_d = ins_req;
            inflight_pc_d = fetch_pc_q;
            if (push) begin
                tail_d = wrap_inc(tail_q);
            end
            if (pop) begin
                head_d = wrap_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            inflight_pc_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i] <= '0;
                pc4_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            if (push) begin
                pc_mem_q[tail_q] <= inflight_pc_q;
                pc4_mem_q[tail_q] <= inflight_pc_q + STEP;
                data_mem_q[tail_q] <= ins_data;
            end
        end
    end

    assign pipe_valid = (count_q != '0);
    assign pipe_pc = pc_mem_q[head_q];
    assign pipe_pc4 = pc4_mem_q[head_q];
    assign pipe_data = data_mem_q[head_q];
    assign occupancy = count_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: DEPTH=4 and DEPTH=3 instances on shared stimulus,
// each checked against an expected sequential-PC stream per fetch segment.
module tb_if_prefetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        control_j;
    logic [31:0] pc_j;
    logic        pipe_ready;

    logic [31:0] d4, a4, pc_4, n4, dat4;
    logic        rq4, pv4;
    logic [2:0]  occ4;
    logic [31:0] d3, a3, pc_3, n3, dat3;
    logic        rq3, pv3;
    logic [1:0]  occ3;

    int total = 0;
    int bad = 0;

    logic [31:0] exp4[$];
    logic [31:0] exp3[$];

    if_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .control_j(control_j), .pc_j(pc_j),
        .ins_data(d4), .pipe_ready(pipe_ready), .ins_req(rq4), .ins_addr(a4),
        .pipe_valid(pv4), .pipe_pc(pc_4), .pipe_pc4(n4), .pipe_data(dat4),
        .occupancy(occ4)
    );

    if_prefetch_queue #(.XLEN(32), .DEPTH(3), .RESET_PC(32'h0), .PC_STEP(4)) dut3 (
        .clk(clk), .reset(reset), .control_j(control_j), .pc_j(pc_j),
        .ins_data(d3), .pipe_ready(pipe_ready), .ins_req(rq3), .ins_addr(a3),
        .pipe_valid(pv3), .pipe_pc(pc_3), .pipe_pc4(n3), .pipe_data(dat3),
        .occupancy(occ3)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    // 1-cycle latency instruction memories
    always @(posedge clk) if (rq4) d4 <= mem_f(a4);
    always @(posedge clk) if (rq3) d3 <= mem_f(a3);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // A new fetch segment delivers start, start+4, ... in order.
    task automatic restart(input logic [31:0] start);
        exp4.delete();
        exp3.delete();
        for (int i = 0; i < 256; i++) begin
            exp4.push_back(start + 32'(i * 4));
            exp3.push_back(start + 32'(i * 4));
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            chk("occ4_le_depth", 32'(occ4 <= 3'd4), 32'd1);
            if (!control_j && pv4 && pipe_ready) begin
                if (exp4.size() == 0) begin
                    chk("dut4_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = exp4.pop_front();
                    chk("dut4_pc", pc_4, e);
                    chk("dut4_pc4", n4, e + 32'd4);
                    chk("dut4_data", dat4, mem_f(e));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            chk("occ3_le_depth", 32'(occ3 <= 2'd3), 32'd1);
            if (!control_j && pv3 && pipe_ready) begin
                if (exp3.size() == 0) begin
                    chk("dut3_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = exp3.pop_front();
                    chk("dut3_pc", pc_3, e);
                    chk("dut3_pc4", n3, e + 32'd4);
                    chk("dut3_data", dat3, mem_f(e));
                end
            end
        end
    end

    task automatic check_reset();
        chk("rst_req4", 32'(rq4), 32'd0);
        chk("rst_addr4", a4, 32'h0);
        chk("rst_valid4", 32'(pv4), 32'd0);
        chk("rst_pc4", pc_4, 32'h0);
        chk("rst_pcn4", n4, 32'h0);
        chk("rst_data4", dat4, 32'h0);
        chk("rst_occ4", 32'(occ4), 32'd0);
        chk("rst_req3", 32'(rq3), 32'd0);
        chk("rst_addr3", a3, 32'h0);
        chk("rst_valid3", 32'(pv3), 32'd0);
        chk("rst_pc3", pc_3, 32'h0);
        chk("rst_pcn3", n3, 32'h0);
        chk("rst_data3", dat3, 32'h0);
        chk("rst_occ3", 32'(occ3), 32'd0);
    endtask

    // Called at the negedge one cycle after the triggering edge.
    task automatic wait_valid(input string nm, input int exp_n);
        int n = 1;
        while (!pv4 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk(nm, 32'(n), 32'(exp_n));
        chk({nm, "_dut3"}, 32'(pv3), 32'd1);
    endtask

    initial begin
        bit found;
        int seg;
        reset = 1'b1;
        control_j = 1'b0;
        pc_j = '0;
        pipe_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();

        // Sequential fetch after reset release
        @(posedge clk); #1;
        restart(32'h0);
        reset = 1'b0;
        pipe_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_valid("reset_latency", 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stream_valid4", 32'(pv4), 32'd1);
            chk("stream_valid3", 32'(pv3), 32'd1);
        end

        // Stall: queue saturates and requests stop
        @(posedge clk); #1;
        pipe_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("sat_occ4", 32'(occ4), 32'd4);
        chk("sat_occ3", 32'(occ3), 32'd3);
        chk("sat_req4", 32'(rq4), 32'd0);
        chk("sat_req3", 32'(rq3), 32'd0);

        // Release: requests resume one cycle later, stream continues
        @(posedge clk); #1;
        pipe_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("resume_req4", 32'(rq4), 32'd1);
        chk("resume_req3", 32'(rq3), 32'd1);
        repeat (6) @(posedge clk);

        // Redirect with 3 entries queued and a fetch in flight
        #1;
        pipe_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (occ4 == 3'd3) found = 1'b1;
        end
        chk("fill3_reached", 32'(found), 32'd1);
        control_j = 1'b1;
        pc_j = 32'h100;
        restart(32'h100);
        @(posedge clk); #1;
        control_j = 1'b0;
        @(negedge clk);
        chk("flush_occ4", 32'(occ4), 32'd0);
        chk("flush_occ3", 32'(occ3), 32'd0);
        wait_valid("redirect_latency", 3);
        chk("redirect_pc4", pc_4, 32'h100);
        @(posedge clk); #1;
        pipe_ready = 1'b1;
        repeat (6) @(posedge clk);

        // Redirect near the top of the address space
        #1;
        control_j = 1'b1;
        pc_j = 32'hFFFF_FFFC;
        restart(32'hFFFF_FFFC);
        @(posedge clk); #1;
        control_j = 1'b0;
        @(negedge clk);
        wait_valid("wrap_latency", 3);
        chk("wrap_pc", pc_4, 32'hFFFF_FFFC);
        chk("wrap_pc4", n4, 32'h0);
        repeat (8) @(posedge clk);

        // DEPTH=3 fill then drain across pointer wrap, with stutter
        #1;
        pipe_ready = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("full_occ3", 32'(occ3), 32'd3);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            pipe_ready = (i % 3) != 2;
        end

        // Randomised ready and redirects
        seg = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            pipe_ready = ($urandom % 4) != 0;
            seg++;
            if (($urandom % 20) == 0 || seg > 60) begin
                control_j = 1'b1;
                if (($urandom % 6) == 0)
                    pc_j = 32'hFFFF_FFF0 + 32'(($urandom % 4) * 4);
                else
                    pc_j = $urandom & 32'hFFFF_FFFC;
                restart(pc_j);
                seg = 0;
            end else begin
                control_j = 1'b0;
            end
        end
        @(posedge clk); #1;
        control_j = 1'b0;
        pipe_ready = 1'b0;
        repeat (5) @(posedge clk);

        // Reset mid-stream
        #1;
        pipe_ready = 1'b1;
        control_j = 1'b1;
        pc_j = 32'h400;
        restart(32'h400);
        @(posedge clk); #1;
        control_j = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        restart(32'h0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wait_valid("rereset_latency", 2);
        chk("rereset_pc", pc_4, 32'h0);
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
